// File: rtl/ecc_apb_pkg.sv
// Shared definitions for the ECC register bank APB path: FSM encoding and register map.
package ecc_apb_pkg;

    // Default bus geometry of the register bank
    localparam int unsigned AMBA_WORD_DEF       = 32;
    localparam int unsigned AMBA_ADDR_WIDTH_DEF = 20;
    localparam int unsigned TIMEOUT_CYCLES_DEF  = 16;

    // Initiator transfer phases
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } apb_state_e;

    // ECC register bank offsets
    localparam int unsigned REG_CTRL           = 32'h0;
    localparam int unsigned REG_DATA_IN        = 32'h4;
    localparam int unsigned REG_CODEWORD_WIDTH = 32'h8;
    localparam int unsigned REG_NOISE          = 32'hC;

endpackage : ecc_apb_pkg

// File: rtl/apb_cmd_initiator_if.sv
// Command/response port plus APB bus of the command initiator.
interface apb_cmd_initiator_if #(
    parameter int unsigned AMBA_WORD       = 32,
    parameter int unsigned AMBA_ADDR_WIDTH = 20
);

    // Command channel
    logic                       cmd_valid;
    logic                       cmd_ready;
    logic                       cmd_write;
    logic [AMBA_ADDR_WIDTH-1:0] cmd_addr;
    logic [AMBA_WORD-1:0]       cmd_wdata;

    // Response channel
    logic                       rsp_valid;
    logic                       rsp_ready;
    logic [AMBA_WORD-1:0]       rsp_rdata;
    logic                       rsp_err;

    // APB bus
    logic                       PSEL;
    logic                       PENABLE;
    logic                       PWRITE;
    logic [AMBA_ADDR_WIDTH-1:0] PADDR;
    logic [AMBA_WORD-1:0]       PWDATA;
    logic [AMBA_WORD-1:0]       PRDATA;
    logic                       PREADY;
    logic                       PSLVERR;

    // Status
    logic                       busy;

    // Initiator side
    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        input  rsp_ready,
        input  PRDATA, PREADY, PSLVERR,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_err,
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output busy
    );

    // Sequencer + register bank side
    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        output rsp_ready,
        output PRDATA, PREADY, PSLVERR,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_err,
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  busy
    );

endinterface : apb_cmd_initiator_if

// File: rtl/apb_cmd_initiator.sv
// APB initiator: turns single-beat valid/ready commands into APB SETUP/ACCESS
// transfers with wait states and a timeout, and returns a valid/ready response.
module apb_cmd_initiator
    import ecc_apb_pkg::*;
#(
    parameter int unsigned AMBA_WORD       = AMBA_WORD_DEF,
    parameter int unsigned AMBA_ADDR_WIDTH = AMBA_ADDR_WIDTH_DEF,
    parameter int unsigned TIMEOUT_CYCLES  = TIMEOUT_CYCLES_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    apb_cmd_initiator_if.master  bus
);

    localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    // State and registered outputs
    apb_state_e                 r_state;
    logic [CNT_W-1:0]           r_cnt;
    logic                       r_psel;
    logic                       r_penable;
    logic                       r_pwrite;
    logic [AMBA_ADDR_WIDTH-1:0] r_paddr;
    logic [AMBA_WORD-1:0]       r_pwdata;
    logic                       r_rsp_valid;
    logic [AMBA_WORD-1:0]       r_rsp_rdata;
    logic                       r_rsp_err;
    logic                       r_busy;

    // Next-state values
    apb_state_e                 w_state_nxt;
    logic [CNT_W-1:0]           w_cnt_nxt;
    logic                       w_psel_nxt;
    logic                       w_penable_nxt;
    logic                       w_pwrite_nxt;
    logic [AMBA_ADDR_WIDTH-1:0] w_paddr_nxt;
    logic [AMBA_WORD-1:0]       w_pwdata_nxt;
    logic                       w_rsp_valid_nxt;
    logic [AMBA_WORD-1:0]       w_rsp_rdata_nxt;
    logic                       w_rsp_err_nxt;
    logic                       w_busy_nxt;

    // Transfer-phase qualifiers
    logic                       w_accept;
    logic                       w_done;
    logic                       w_timeout;
    logic                       w_rsp_take;

    assign w_accept   = (r_state == ST_IDLE)   && bus.cmd_valid;
    assign w_done     = (r_state == ST_ACCESS) && bus.PREADY;
    // Last allowed wait cycle with PREADY still low ends the transfer
    assign w_timeout  = (r_state == ST_ACCESS) && !bus.PREADY && (r_cnt == CNT_LAST);
    assign w_rsp_take = (r_state == ST_RESP)   && bus.rsp_ready;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ST_SETUP;
                end
            end
            ST_SETUP: begin
                w_state_nxt = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (w_done || w_timeout) begin
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                if (w_rsp_take) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Output logic: next values of every registered output and the wait counter
    always_comb begin
        w_cnt_nxt       = r_cnt;
        w_psel_nxt      = r_psel;
        w_penable_nxt   = r_penable;
        w_pwrite_nxt    = r_pwrite;
        w_paddr_nxt     = r_paddr;
        w_pwdata_nxt    = r_pwdata;
        w_rsp_valid_nxt = r_rsp_valid;
        w_rsp_rdata_nxt = r_rsp_rdata;
        w_rsp_err_nxt   = r_rsp_err;
        w_busy_nxt      = (w_state_nxt != ST_IDLE);

        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    // Address phase values stay put until the response is captured
                    w_pwrite_nxt = bus.cmd_write;
                    w_paddr_nxt  = bus.cmd_addr;
                    w_pwdata_nxt = bus.cmd_wdata;
                    w_psel_nxt   = 1'b1;
                end
            end
            ST_SETUP: begin
                w_penable_nxt = 1'b1;
                w_cnt_nxt     = '0;
            end
            ST_ACCESS: begin
                if (bus.PREADY) begin
                    w_psel_nxt      = 1'b0;
                    w_penable_nxt   = 1'b0;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_err_nxt   = bus.PSLVERR;
                    // Writes and errored reads return zero data
                    w_rsp_rdata_nxt = (r_pwrite || bus.PSLVERR) ? '0 : bus.PRDATA;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                    if (w_timeout) begin
                        w_psel_nxt      = 1'b0;
                        w_penable_nxt   = 1'b0;
                        w_rsp_valid_nxt = 1'b1;
                        w_rsp_err_nxt   = 1'b1;
                        w_rsp_rdata_nxt = '0;
                    end
                end
            end
            ST_RESP: begin
                if (w_rsp_take) begin
                    w_rsp_valid_nxt = 1'b0;
                end
            end
            default: begin
                w_psel_nxt      = 1'b0;
                w_penable_nxt   = 1'b0;
                w_rsp_valid_nxt = 1'b0;
            end
        endcase
    end

    // Output and counter registers; reset discards any transfer in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt       <= '0;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_pwrite    <= 1'b0;
            r_paddr     <= '0;
            r_pwdata    <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_cnt       <= w_cnt_nxt;
            r_psel      <= w_psel_nxt;
            r_penable   <= w_penable_nxt;
            r_pwrite    <= w_pwrite_nxt;
            r_paddr     <= w_paddr_nxt;
            r_pwdata    <= w_pwdata_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_rdata <= w_rsp_rdata_nxt;
            r_rsp_err   <= w_rsp_err_nxt;
            r_busy      <= w_busy_nxt;
        end
    end

    // Port drive; cmd_ready is the only combinational output
    assign bus.cmd_ready = (r_state == ST_IDLE);
    assign bus.PSEL      = r_psel;
    assign bus.PENABLE   = r_penable;
    assign bus.PWRITE    = r_pwrite;
    assign bus.PADDR     = r_paddr;
    assign bus.PWDATA    = r_pwdata;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.rsp_err   = r_rsp_err;
    assign bus.busy      = r_busy;

endmodule : apb_cmd_initiator

// File: tb/tb_apb_cmd_initiator.sv
// Directed bench for apb_cmd_initiator acting against a scripted APB slave.
module tb_apb_cmd_initiator;
    import ecc_apb_pkg::*;

    localparam int unsigned AW = 20;
    localparam int unsigned DW = 32;
    localparam int unsigned TO = 16;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_err;

    apb_cmd_initiator_if #(.AMBA_WORD(DW), .AMBA_ADDR_WIDTH(AW)) bus ();

    apb_cmd_initiator #(
        .AMBA_WORD       (DW),
        .AMBA_ADDR_WIDTH (AW),
        .TIMEOUT_CYCLES  (TO)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge and sample away from it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one command and let it be accepted on the next edge
    task automatic issue(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_addr  = addr;
        bus.cmd_wdata = wd;
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    // Consume the pending response
    task automatic take_rsp();
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk = 0;
        n_err = 0;
        rst           = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        bus.rsp_ready = 1'b0;
        bus.PRDATA    = '0;
        bus.PREADY    = 1'b1;
        bus.PSLVERR   = 1'b0;
        tick();
        tick();

        // Reset state
        chk("rst_psel",      32'(bus.PSEL),      32'd0);
        chk("rst_penable",   32'(bus.PENABLE),   32'd0);
        chk("rst_pwrite",    32'(bus.PWRITE),    32'd0);
        chk("rst_paddr",     32'(bus.PADDR),     32'd0);
        chk("rst_pwdata",    bus.PWDATA,         32'd0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_rdata", bus.rsp_rdata,      32'd0);
        chk("rst_rsp_err",   32'(bus.rsp_err),   32'd0);
        chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        chk("rst_busy",      32'(bus.busy),      32'd0);
        rst = 1'b0;
        tick();

        // 1: write CODEWORD_WIDTH <- 0x20, zero wait states
        issue(1'b1, AW'(REG_CODEWORD_WIDTH), 32'h20);
        chk("w_setup_psel",    32'(bus.PSEL),      32'd1);
        chk("w_setup_penable", 32'(bus.PENABLE),   32'd0);
        chk("w_setup_pwrite",  32'(bus.PWRITE),    32'd1);
        chk("w_setup_paddr",   32'(bus.PADDR),     32'h8);
        chk("w_setup_pwdata",  bus.PWDATA,         32'h20);
        chk("w_setup_ready",   32'(bus.cmd_ready), 32'd0);
        chk("w_setup_busy",    32'(bus.busy),      32'd1);
        tick();
        chk("w_acc_psel",      32'(bus.PSEL),      32'd1);
        chk("w_acc_penable",   32'(bus.PENABLE),   32'd1);
        chk("w_acc_pwdata",    bus.PWDATA,         32'h20);
        chk("w_acc_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        tick();
        chk("w_rsp_valid",     32'(bus.rsp_valid), 32'd1);
        chk("w_rsp_psel",      32'(bus.PSEL),      32'd0);
        chk("w_rsp_penable",   32'(bus.PENABLE),   32'd0);
        chk("w_rsp_rdata",     bus.rsp_rdata,      32'd0);
        chk("w_rsp_err",       32'(bus.rsp_err),   32'd0);
        take_rsp();
        chk("w_done_valid",    32'(bus.rsp_valid), 32'd0);
        chk("w_done_ready",    32'(bus.cmd_ready), 32'd1);
        chk("w_done_busy",     32'(bus.busy),      32'd0);

        // 2: read NOISE, zero wait states
        bus.PRDATA = 32'hA5A5_0001;
        issue(1'b0, AW'(REG_NOISE), 32'hFFFF_FFFF);
        chk("r_setup_pwrite", 32'(bus.PWRITE), 32'd0);
        chk("r_setup_paddr",  32'(bus.PADDR),  32'hC);
        tick();
        tick();
        chk("r_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        chk("r_rsp_rdata", bus.rsp_rdata,      32'hA5A5_0001);
        chk("r_rsp_err",   32'(bus.rsp_err),   32'd0);
        take_rsp();

        // 3: read DATA_IN with three wait states
        bus.PREADY = 1'b0;
        bus.PRDATA = 32'h1234_5678;
        issue(1'b0, AW'(REG_DATA_IN), 32'h0);
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("ws_penable", 32'(bus.PENABLE),   32'd1);
            chk("ws_paddr",   32'(bus.PADDR),     32'h4);
            chk("ws_valid",   32'(bus.rsp_valid), 32'd0);
            tick();
        end
        chk("ws_last_penable", 32'(bus.PENABLE), 32'd1);
        bus.PREADY = 1'b1;
        tick();
        chk("ws_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        chk("ws_rsp_rdata", bus.rsp_rdata,      32'h1234_5678);
        chk("ws_rsp_err",   32'(bus.rsp_err),   32'd0);
        take_rsp();

        // 4: PREADY stuck low -> timeout after 16 ACCESS cycles
        bus.PREADY = 1'b0;
        bus.PRDATA = 32'hCAFE_F00D;
        issue(1'b0, AW'(REG_CTRL), 32'h0);
        tick();
        for (int i = 0; i < 15; i++) tick();
        chk("to_last_psel",    32'(bus.PSEL),      32'd1);
        chk("to_last_penable", 32'(bus.PENABLE),   32'd1);
        chk("to_last_valid",   32'(bus.rsp_valid), 32'd0);
        tick();
        chk("to_psel",      32'(bus.PSEL),      32'd0);
        chk("to_penable",   32'(bus.PENABLE),   32'd0);
        chk("to_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        chk("to_rsp_err",   32'(bus.rsp_err),   32'd1);
        chk("to_rsp_rdata", bus.rsp_rdata,      32'd0);
        take_rsp();
        bus.PREADY = 1'b1;

        // 5: response back-pressure with a second command waiting
        bus.PRDATA = 32'hDEAD_BEEF;
        issue(1'b0, AW'(REG_NOISE), 32'h0);
        tick();
        tick();
        bus.PRDATA    = 32'h0;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b1;
        bus.cmd_addr  = AW'(REG_DATA_IN);
        bus.cmd_wdata = 32'h55;
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 32'(bus.rsp_valid), 32'd1);
            chk("bp_rdata", bus.rsp_rdata,      32'hDEAD_BEEF);
            chk("bp_ready", 32'(bus.cmd_ready), 32'd0);
            chk("bp_psel",  32'(bus.PSEL),      32'd0);
            tick();
        end
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        chk("bp_hs_valid", 32'(bus.rsp_valid), 32'd0);
        chk("bp_hs_ready", 32'(bus.cmd_ready), 32'd1);
        chk("bp_hs_psel",  32'(bus.PSEL),      32'd0);
        tick();
        bus.cmd_valid = 1'b0;
        chk("bp2_psel",   32'(bus.PSEL),   32'd1);
        chk("bp2_paddr",  32'(bus.PADDR),  32'h4);
        chk("bp2_pwdata", bus.PWDATA,      32'h55);
        tick();
        tick();
        chk("bp2_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        chk("bp2_rsp_rdata", bus.rsp_rdata,      32'd0);
        chk("bp2_rsp_err",   32'(bus.rsp_err),   32'd0);
        take_rsp();

        // 6a: reset during ACCESS discards the transfer
        bus.PREADY = 1'b0;
        issue(1'b0, AW'(REG_CODEWORD_WIDTH), 32'h0);
        tick();
        chk("mr_acc_penable", 32'(bus.PENABLE), 32'd1);
        rst = 1'b1;
        tick();
        chk("mr_psel",    32'(bus.PSEL),      32'd0);
        chk("mr_penable", 32'(bus.PENABLE),   32'd0);
        chk("mr_valid",   32'(bus.rsp_valid), 32'd0);
        chk("mr_ready",   32'(bus.cmd_ready), 32'd1);
        chk("mr_busy",    32'(bus.busy),      32'd0);
        rst        = 1'b0;
        bus.PREADY = 1'b1;
        tick();
        tick();
        chk("mr_no_rsp", 32'(bus.rsp_valid), 32'd0);

        // 6b: PSLVERR with PREADY forces error and zero data
        bus.PSLVERR = 1'b1;
        bus.PRDATA  = 32'hFFFF_FFFF;
        issue(1'b0, AW'(REG_CTRL), 32'h0);
        tick();
        tick();
        chk("se_valid", 32'(bus.rsp_valid), 32'd1);
        chk("se_err",   32'(bus.rsp_err),   32'd1);
        chk("se_rdata", bus.rsp_rdata,      32'd0);
        take_rsp();

        // 6c: PSLVERR while PREADY is low is ignored
        bus.PREADY = 1'b0;
        bus.PRDATA = 32'h0BAD_0001;
        issue(1'b0, AW'(REG_DATA_IN), 32'h0);
        tick();
        tick();
        tick();
        bus.PSLVERR = 1'b0;
        bus.PREADY  = 1'b1;
        tick();
        chk("si_valid", 32'(bus.rsp_valid), 32'd1);
        chk("si_err",   32'(bus.rsp_err),   32'd0);
        chk("si_rdata", bus.rsp_rdata,      32'h0BAD_0001);
        take_rsp();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule : tb_apb_cmd_initiator
